load_store_unit: RTL and testbench

Memory-stage request initiator for the 16-bit pipelined processor. It accepts one decoded EX-stage operation at a time: ALU pass-through, load or store. It drives the data memory block's request port (ans_ex, DM_data, mem_rw_ex, mem_en_ex, mem_mux_sel_dm) and holds each access for a configurable number of wait states. It then takes the memory's ans_dm result and presents it to write-back with a one-cycle valid pulse, stalling EX through ex_ready while an access is in flight.

---
 rtl/load_store_unit_if.sv | 43 ++++
 rtl/load_store_unit.sv | 154 +++++++++++++++
 tb/tb_load_store_unit.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Bundles the EX-stage handshake, the data-memory request/response port and
//   the write-back port of the load/store unit.
//   slave  : the load/store unit itself
//   master : the surrounding pipeline / data memory (or a testbench)
//   EX side   : ex_valid, ex_ready, ex_op, ex_result, ex_store_data, ex_rd
//   Memory    : ans_ex, DM_data, mem_rw_ex, mem_en_ex, mem_mux_sel_dm, ans_dm
//   Write-back: wb_valid, wb_we, wb_rd, wb_data
//   Status    : illegal_op
interface load_store_unit_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  ex_op;
  logic [15:0] ex_result;
  logic [15:0] ex_store_data;
  logic [2:0]  ex_rd;

  logic [15:0] ans_ex;
  logic [15:0] DM_data;
  logic        mem_rw_ex;
  logic        mem_en_ex;
  logic        mem_mux_sel_dm;
  logic [15:0] ans_dm;

  logic        wb_valid;
  logic        wb_we;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;

  logic        illegal_op;

  modport slave (
    input  ex_valid, ex_op, ex_result, ex_store_data, ex_rd, ans_dm,
    output ex_ready, ans_ex, DM_data, mem_rw_ex, mem_en_ex, mem_mux_sel_dm,
           wb_valid, wb_we, wb_rd, wb_data, illegal_op
  );

  modport master (
    output ex_valid, ex_op, ex_result, ex_store_data, ex_rd, ans_dm,
    input  ex_ready, ans_ex, DM_data, mem_rw_ex, mem_en_ex, mem_mux_sel_dm,
           wb_valid, wb_we, wb_rd, wb_data, illegal_op
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage request initiator. Accepts one EX operation at a time (ALU
//   pass-through, load or store), drives the data-memory request for
//   MEM_WAIT+1 cycles on loads/stores (one cycle, with the enable low, for
//   ALU ops), then raises a one-cycle write-back pulse while the memory's
//   registered result is on ans_dm.
// Ports
//   clk_i    : clock, all state changes on the rising edge
//   reset_ni : asynchronous active-low reset, clears all state immediately
//   lsu      : load_store_unit_if.slave (EX handshake, memory port, write-back)
// Parameters
//   MEM_WAIT : extra wait cycles per load/store access, 0..7
module load_store_unit #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  load_store_unit_if.slave  lsu
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [1:0] OP_ALU   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

  state_e      state_q;
  logic [2:0]  wcnt_q;
  logic [15:0] ans_ex_q;
  logic [15:0] dm_data_q;
  logic        mem_rw_q;
  logic        mem_en_q;
  logic        mux_sel_q;
  logic [2:0]  rd_q;
  logic        we_pend_q;   // write enable the in-flight op will retire with
  logic        wb_valid_q;
  logic        wb_we_q;
  logic [2:0]  wb_rd_q;
  logic        illegal_q;

  logic        ready_s;
  logic        accept_s;

  // Ready is also gated by reset so EX sees a stall for as long as reset is held.
  always_comb begin
    ready_s  = 1'b0;
    accept_s = 1'b0;
    if (!reset_ni) begin
      ready_s = 1'b0;
    end else if (state_q == ACCESS) begin
      ready_s = 1'b0;
    end else begin
      ready_s = 1'b1;
    end
    accept_s = ready_s & lsu.ex_valid;
  end

  // Request/response FSM; every output below is a register of this block.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      wcnt_q     <= 3'd0;
      ans_ex_q   <= 16'd0;
      dm_data_q  <= 16'd0;
      mem_rw_q   <= 1'b0;
      mem_en_q   <= 1'b0;
      mux_sel_q  <= 1'b0;
      rd_q       <= 3'd0;
      we_pend_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= 3'd0;
      illegal_q  <= 1'b0;
    end else begin
      // Retire pulse lasts exactly one cycle.
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          mem_en_q <= 1'b0;
          mem_rw_q <= 1'b0;
          if (accept_s) begin
            case (lsu.ex_op)
              OP_LOAD, OP_STORE: begin
                ans_ex_q  <= lsu.ex_result;
                dm_data_q <= lsu.ex_store_data;
                mem_en_q  <= 1'b1;
                mem_rw_q  <= (lsu.ex_op == OP_STORE);
                mux_sel_q <= (lsu.ex_op == OP_LOAD);
                wcnt_q    <= WAIT_INIT;
                rd_q      <= lsu.ex_rd;
                we_pend_q <= (lsu.ex_op == OP_LOAD) && (lsu.ex_rd != 3'd0);
                state_q   <= ACCESS;
              end
              OP_ALU: begin
                // One ACCESS cycle with the enable low lets the value travel
                // through the memory's output register onto ans_dm.
                ans_ex_q  <= lsu.ex_result;
                mux_sel_q <= 1'b0;
                wcnt_q    <= 3'd0;
                rd_q      <= lsu.ex_rd;
                we_pend_q <= (lsu.ex_rd != 3'd0);
                state_q   <= ACCESS;
              end
              default: begin
                illegal_q <= 1'b1;
                state_q   <= IDLE;
              end
            endcase
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          if (wcnt_q != 3'd0) begin
            wcnt_q <= wcnt_q - 3'd1;
          end else begin
            // Final edge: memory samples the request now, result shows next cycle.
            mem_en_q   <= 1'b0;
            mem_rw_q   <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_we_q    <= we_pend_q;
            wb_rd_q    <= rd_q;
            state_q    <= RESP;
          end
        end
        default: begin
          mem_en_q <= 1'b0;
          mem_rw_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign lsu.ex_ready       = ready_s;
  assign lsu.ans_ex         = ans_ex_q;
  assign lsu.DM_data        = dm_data_q;
  assign lsu.mem_rw_ex      = mem_rw_q;
  assign lsu.mem_en_ex      = mem_en_q;
  assign lsu.mem_mux_sel_dm = mux_sel_q;
  assign lsu.wb_valid       = wb_valid_q;
  assign lsu.wb_we          = wb_we_q;
  assign lsu.wb_rd          = wb_rd_q;
  // The memory already registers its output, so write-back data is a wire.
  assign lsu.wb_data        = lsu.ans_dm;
  assign lsu.illegal_op     = illegal_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: two instances (MEM_WAIT=0 and MEM_WAIT=3),
// each with a small registered data-memory model. Expected retirements are
// queued when an op is accepted and compared when wb_valid pulses.
module tb_load_store_unit;

  localparam int NDUT = 2;
  localparam int unsigned W1 = 3;
  localparam logic [1:0] OP_ALU = 2'b00, OP_LOAD = 2'b01, OP_STORE = 2'b10, OP_ILL = 2'b11;

  typedef struct {
    logic [2:0]  rd;
    logic        we;
    logic [15:0] data;
    logic        chk_data;
    int unsigned acc;
    int unsigned lat;
  } exp_t;

  logic clk;
  logic        rst_n     [NDUT];
  logic        ex_valid  [NDUT];
  logic [1:0]  ex_op     [NDUT];
  logic [15:0] ex_result [NDUT];
  logic [15:0] ex_sdata  [NDUT];
  logic [2:0]  ex_rd     [NDUT];
  logic        ex_ready  [NDUT];
  logic        mem_en    [NDUT];
  logic        mem_rw    [NDUT];
  logic        mux_sel   [NDUT];
  logic        wb_valid  [NDUT];
  logic        wb_we     [NDUT];
  logic        illegal   [NDUT];
  logic [15:0] ans_ex    [NDUT];
  logic [15:0] dm_data   [NDUT];
  logic [15:0] wb_data   [NDUT];
  logic [2:0]  wb_rd     [NDUT];
  logic        init_done;

  logic [15:0] ref_mem [NDUT][16];
  exp_t sb0[$];
  exp_t sb1[$];
  int unsigned cyc = 0;
  int unsigned last_acc [NDUT];
  int en_cnt [NDUT], rw_cnt [NDUT], nrdy_cnt [NDUT], wb_cnt [NDUT], run_len [NDUT];
  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    load_store_unit_if u_if ();
    logic [15:0] mem [16];

    load_store_unit #(.MEM_WAIT((g == 0) ? 32'd0 : W1)) u_dut (
      .clk_i    (clk),
      .reset_ni (rst_n[g]),
      .lsu      (u_if.slave)
    );

    assign u_if.ex_valid      = ex_valid[g];
    assign u_if.ex_op         = ex_op[g];
    assign u_if.ex_result     = ex_result[g];
    assign u_if.ex_store_data = ex_sdata[g];
    assign u_if.ex_rd         = ex_rd[g];
    assign ex_ready[g] = u_if.ex_ready;
    assign mem_en[g]   = u_if.mem_en_ex;
    assign mem_rw[g]   = u_if.mem_rw_ex;
    assign mux_sel[g]  = u_if.mem_mux_sel_dm;
    assign wb_valid[g] = u_if.wb_valid;
    assign wb_we[g]    = u_if.wb_we;
    assign illegal[g]  = u_if.illegal_op;
    assign ans_ex[g]   = u_if.ans_ex;
    assign dm_data[g]  = u_if.DM_data;
    assign wb_data[g]  = u_if.wb_data;
    assign wb_rd[g]    = u_if.wb_rd;

    // Data memory model: synchronous write, registered result mux.
    always @(posedge clk) begin
      if (!init_done) begin
        for (int i = 0; i < 16; i++) mem[i] <= 16'hA000 + 16'(i);
      end else if (u_if.mem_en_ex && u_if.mem_rw_ex) begin
        mem[u_if.ans_ex[3:0]] <= u_if.DM_data;
      end
      u_if.ans_dm <= u_if.mem_mux_sel_dm ? mem[u_if.ans_ex[3:0]] : u_if.ans_ex;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned wait_of(input int d);
    return (d == 0) ? 32'd0 : W1;
  endfunction

  task automatic sb_pop_check(input int d);
    exp_t e;
    int sz;
    sz = (d == 0) ? sb0.size() : sb1.size();
    check_eq("sb_nonempty", 32'(sz != 0), 32'd1);
    if (sz != 0) begin
      if (d == 0) e = sb0.pop_front();
      else        e = sb1.pop_front();
      check_eq("wb_rd", 32'(wb_rd[d]), 32'(e.rd));
      check_eq("wb_we", 32'(wb_we[d]), 32'(e.we));
      if (e.chk_data) check_eq("wb_data", 32'(wb_data[d]), 32'(e.data));
      check_eq("wb_latency", cyc - e.acc, e.lat);
    end
  endtask

  // Monitor: activity counters, pulse width and scoreboard compare.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (rst_n[d]) begin
        if (mem_en[d]) en_cnt[d]++;
        if (mem_en[d] && mem_rw[d]) rw_cnt[d]++;
        if (!ex_ready[d]) nrdy_cnt[d]++;
        if (wb_valid[d]) begin
          wb_cnt[d]++;
          run_len[d]++;
          check_eq("wb_pulse_len", 32'(run_len[d]), 32'd1);
          sb_pop_check(d);
        end else begin
          run_len[d] = 0;
        end
      end
    end
  end

  task automatic clr_cnt(input int d);
    en_cnt[d] = 0; rw_cnt[d] = 0; nrdy_cnt[d] = 0; wb_cnt[d] = 0;
  endtask

  // Present an op and hold it until accepted; queue its expected retirement.
  task automatic issue(input int d, input logic [1:0] op, input logic [15:0] res,
                       input logic [15:0] sd, input logic [2:0] rd, input bit track);
    exp_t e;
    bit got;
    ex_op[d] = op; ex_result[d] = res; ex_sdata[d] = sd; ex_rd[d] = rd;
    ex_valid[d] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ex_ready[d]) got = 1'b1;
      @(posedge clk); #1;
    end
    check_eq("accept_timeout", 32'(got), 32'd1);
    last_acc[d] = cyc;
    if (got && track && op != OP_ILL) begin
      e.rd = rd;
      e.acc = cyc;
      e.lat = (op == OP_ALU) ? 32'd1 : wait_of(d) + 32'd1;
      e.we = (op != OP_STORE) && (rd != 3'd0);
      e.chk_data = (op != OP_STORE);
      e.data = (op == OP_LOAD) ? ref_mem[d][res[3:0]] : res;
      if (op == OP_STORE) ref_mem[d][res[3:0]] = sd;
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
  endtask

  task automatic idle(input int d);
    ex_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (((d == 0) ? sb0.size() : sb1.size()) == 0 && ex_ready[d]) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check_eq("drain", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned prev;
    init_done = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      rst_n[d] = 1'b0; ex_valid[d] = 1'b1; ex_op[d] = OP_LOAD; ex_result[d] = 16'h0003;
      ex_sdata[d] = 16'h1111; ex_rd[d] = 3'd1; last_acc[d] = 0; run_len[d] = 0;
      clr_cnt(d);
      for (int i = 0; i < 16; i++) ref_mem[d][i] = 16'hA000 + 16'(i);
    end

    // Reset held with a pending op: everything quiet, no ready.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check_eq("rst_ex_ready", 32'(ex_ready[d]), 32'd0);
      check_eq("rst_mem_en", 32'(mem_en[d]), 32'd0);
      check_eq("rst_mem_rw", 32'(mem_rw[d]), 32'd0);
      check_eq("rst_mux_sel", 32'(mux_sel[d]), 32'd0);
      check_eq("rst_wb_valid", 32'(wb_valid[d]), 32'd0);
      check_eq("rst_wb_we", 32'(wb_we[d]), 32'd0);
      check_eq("rst_wb_rd", 32'(wb_rd[d]), 32'd0);
      check_eq("rst_ans_ex", 32'(ans_ex[d]), 32'd0);
      check_eq("rst_dm_data", 32'(dm_data[d]), 32'd0);
      check_eq("rst_illegal", 32'(illegal[d]), 32'd0);
      check_eq("rst_wb_data", 32'(wb_data[d]), 32'd0);
      ex_valid[d] = 1'b0;
      rst_n[d] = 1'b1;
    end
    init_done = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) check_eq("idle_ex_ready", 32'(ex_ready[d]), 32'd1);
    @(posedge clk); #1;

    // MEM_WAIT=0: store FFFF to 3, then load it back into r5.
    clr_cnt(0);
    issue(0, OP_STORE, 16'h0003, 16'hFFFF, 3'd1, 1'b1);
    idle(0); drain(0);
    check_eq("st_en_cycles", 32'(en_cnt[0]), 32'd1);
    check_eq("st_rw_cycles", 32'(rw_cnt[0]), 32'd1);
    check_eq("st_wb_pulses", 32'(wb_cnt[0]), 32'd1);
    clr_cnt(0);
    issue(0, OP_LOAD, 16'h0003, 16'h0000, 3'd5, 1'b1);
    idle(0); drain(0);
    check_eq("ld_en_cycles", 32'(en_cnt[0]), 32'd1);
    check_eq("ld_rw_cycles", 32'(rw_cnt[0]), 32'd0);

    // ALU pass-through: no memory enable, mux selects ans_ex.
    clr_cnt(0);
    issue(0, OP_ALU, 16'h1234, 16'h0000, 3'd2, 1'b1);
    idle(0);
    @(negedge clk);
    check_eq("alu_mux_sel", 32'(mux_sel[0]), 32'd0);
    check_eq("alu_ans_ex", 32'(ans_ex[0]), 32'h1234);
    drain(0);
    check_eq("alu_en_cycles", 32'(en_cnt[0]), 32'd0);

    // MEM_WAIT=3 load: four stalled cycles, four enabled cycles, one retire.
    clr_cnt(1);
    issue(1, OP_LOAD, 16'h0002, 16'h0000, 3'd4, 1'b1);
    idle(1); drain(1);
    check_eq("w3_not_ready", 32'(nrdy_cnt[1]), 32'd4);
    check_eq("w3_en_cycles", 32'(en_cnt[1]), 32'd4);
    check_eq("w3_wb_pulses", 32'(wb_cnt[1]), 32'd1);

    // Back-to-back ALU ops with ex_valid held: one accept every 2 cycles.
    clr_cnt(0);
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      issue(0, OP_ALU, 16'h0100 + 16'(k), 16'h0000, 3'(k), 1'b1);
      if (k > 0) check_eq("b2b_spacing", last_acc[0] - prev, 32'd2);
      prev = last_acc[0];
    end
    idle(0); drain(0);
    check_eq("b2b_wb_pulses", 32'(wb_cnt[0]), 32'd5);

    // Reserved op: sticky flag, no retire, unit stays usable.
    clr_cnt(1);
    issue(1, OP_ILL, 16'h0009, 16'h0000, 3'd4, 1'b1);
    idle(1);
    @(negedge clk);
    check_eq("ill_flag", 32'(illegal[1]), 32'd1);
    check_eq("ill_ready", 32'(ex_ready[1]), 32'd1);
    @(posedge clk); #1;
    issue(1, OP_ALU, 16'h55AA, 16'h0000, 3'd6, 1'b1);
    idle(1); drain(1);
    check_eq("ill_sticky", 32'(illegal[1]), 32'd1);
    check_eq("ill_wb_pulses", 32'(wb_cnt[1]), 32'd1);

    // Store to 7 cut by reset before the memory samples it.
    issue(1, OP_STORE, 16'h0007, 16'h5555, 3'd0, 1'b0);
    idle(1);
    @(negedge clk);
    check_eq("abort_en_before", 32'(mem_en[1]), 32'd1);
    rst_n[1] = 1'b0;
    #1;
    check_eq("abort_en_drop", 32'(mem_en[1]), 32'd0);
    check_eq("abort_rw_drop", 32'(mem_rw[1]), 32'd0);
    check_eq("abort_illegal_clr", 32'(illegal[1]), 32'd0);
    check_eq("abort_not_ready", 32'(ex_ready[1]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
    issue(1, OP_LOAD, 16'h0007, 16'h0000, 3'd3, 1'b1);
    idle(1); drain(1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
